// File: rtl/spi_slave_regfile.sv
// SPI Mode-0 responder for 32-bit command/data frames backed by a 16-bit register file.
// SPI pins are oversampled by clk; a local host port shares the register file.
module spi_slave_regfile #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk_in,
  input  logic              spi_mosi_in,
  input  logic              spi_cs_n_in,
  output logic              spi_miso_out,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [15:0]       host_wdata,
  output logic [15:0]       host_rdata,
  output logic              frame_done,
  output logic              frame_is_read,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [15:0]       frame_wdata,
  output logic              frame_abort
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam logic [15:0] CmdUsedMask = 16'((((1 << ADDR_W) - 1) << 3) | 2);

  typedef enum logic [1:0] {StIdle, StCmd, StData, StHold} state_e;

  logic [15:0] mem [Depth];

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_n_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, mosi_s, cs_active;
  logic                   sclk_rise, sclk_fall;

  state_e            state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [14:0]       cmd_sr_q, cmd_sr_d;
  logic [14:0]       data_sr_q, data_sr_d;
  logic [15:0]       tx_sr_q, tx_sr_d;
  logic              miso_q, miso_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              armed_q, armed_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic              f_is_read_q, f_is_read_d;
  logic [ADDR_W-1:0] f_addr_q, f_addr_d;
  logic [15:0]       f_wdata_q, f_wdata_d;
  logic [15:0]       host_rdata_q;

  logic [15:0]       cmd_full, data_full;
  logic [ADDR_W-1:0] cmd_addr;
  logic              spi_we;
  logic              unused_cmd_bits;

  // Input synchronizers and SCLK edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_n_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_in};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_in};
      cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], spi_cs_n_in};
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_active = ~cs_n_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  assign cmd_full        = {cmd_sr_q, mosi_s};
  assign data_full       = {data_sr_q, mosi_s};
  assign cmd_addr        = cmd_full[ADDR_W+2:3];
  assign unused_cmd_bits = ^(cmd_full & ~CmdUsedMask);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_sr_d    = cmd_sr_q;
    data_sr_d   = data_sr_q;
    tx_sr_d     = tx_sr_q;
    miso_d      = miso_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    // A frame may only start once CS has been seen high since reset
    armed_d     = armed_q | ~cs_active;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    f_is_read_d = f_is_read_q;
    f_addr_d    = f_addr_q;
    f_wdata_d   = f_wdata_q;
    spi_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        miso_d    = 1'b0;
        if (cs_active) begin
          state_d = armed_q ? StCmd : StHold;
        end
      end

      StCmd: begin
        if (!cs_active) begin
          abort_d   = 1'b1;
          miso_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = StIdle;
        end else if (sclk_rise) begin
          cmd_sr_d  = cmd_full[14:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd15) begin
            addr_d  = cmd_addr;
            rd_d    = cmd_full[1];
            if (cmd_full[1]) begin
              tx_sr_d = mem[cmd_addr];
            end
            state_d = StData;
          end
        end
      end

      StData: begin
        if (!cs_active) begin
          abort_d   = 1'b1;
          miso_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = StIdle;
        end else if (sclk_rise) begin
          data_sr_d = data_full[14:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd31) begin
            spi_we      = ~rd_q;
            f_is_read_d = rd_q;
            f_addr_d    = addr_q;
            f_wdata_d   = data_full;
            done_d      = 1'b1;
            miso_d      = 1'b0;
            bit_cnt_d   = '0;
            state_d     = StHold;
          end
        end else if (sclk_fall && rd_q) begin
          miso_d  = tx_sr_q[15];
          tx_sr_d = {tx_sr_q[14:0], 1'b0};
        end
      end

      StHold: begin
        miso_d = 1'b0;
        if (!cs_active) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      cmd_sr_q    <= '0;
      data_sr_q   <= '0;
      tx_sr_q     <= '0;
      miso_q      <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      f_is_read_q <= 1'b0;
      f_addr_q    <= '0;
      f_wdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_sr_q    <= cmd_sr_d;
      data_sr_q   <= data_sr_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      f_is_read_q <= f_is_read_d;
      f_addr_q    <= f_addr_d;
      f_wdata_q   <= f_wdata_d;
    end
  end

  // Register file is not reset; an SPI commit beats a host write to the same word
  always_ff @(posedge clk) begin
    if (spi_we) begin
      mem[addr_q] <= data_full;
    end
    if (host_we && !(spi_we && (host_addr == addr_q))) begin
      mem[host_addr] <= host_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      host_rdata_q <= '0;
    end else begin
      host_rdata_q <= mem[host_addr];
    end
  end

  assign spi_miso_out  = miso_q;
  assign host_rdata    = host_rdata_q;
  assign frame_done    = done_q;
  assign frame_abort   = abort_q;
  assign frame_is_read = f_is_read_q;
  assign frame_addr    = f_addr_q;
  assign frame_wdata   = f_wdata_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile: bit-banged SPI master, host port and
// a scoreboard of expected frame reports and read-back words.
module tb_spi_slave_regfile;

  localparam int ADDR_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 10;

  typedef struct {
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
  } frame_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              spi_sclk = 1'b0;
  logic              spi_mosi = 1'b0;
  logic              spi_cs_n = 1'b1;
  logic              spi_miso;
  logic              host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [15:0]       host_wdata = '0;
  logic [15:0]       host_rdata;
  logic              frame_done;
  logic              frame_is_read;
  logic [ADDR_W-1:0] frame_addr;
  logic [15:0]       frame_wdata;
  logic              frame_abort;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  logic [15:0] model [1 << ADDR_W];
  frame_t      exp_frames [$];
  logic [15:0] exp_reads [$];

  spi_slave_regfile #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi_sclk_in   (spi_sclk),
    .spi_mosi_in   (spi_mosi),
    .spi_cs_n_in   (spi_cs_n),
    .spi_miso_out  (spi_miso),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_rdata    (host_rdata),
    .frame_done    (frame_done),
    .frame_is_read (frame_is_read),
    .frame_addr    (frame_addr),
    .frame_wdata   (frame_wdata),
    .frame_abort   (frame_abort)
  );

  always #5 clk = ~clk;

  // Frame-report scoreboard: each frame_done pops one expected frame
  always @(negedge clk) begin
    if (frame_abort) abort_cnt++;
    if (frame_done) begin
      frame_t e;
      done_cnt++;
      vectors++;
      if (exp_frames.size() == 0) begin
        miscompares++;
        $display("FAIL frame_unexpected: got rd=%0b addr=%h wdata=%h, none expected",
                 frame_is_read, frame_addr, frame_wdata);
      end else begin
        e = exp_frames.pop_front();
        if ({frame_is_read, frame_addr, frame_wdata} !== {e.rd, e.addr, e.wdata}) begin
          miscompares++;
          $display("FAIL frame_report: got rd=%0b addr=%h wdata=%h, expected rd=%0b addr=%h wdata=%h",
                   frame_is_read, frame_addr, frame_wdata, e.rd, e.addr, e.wdata);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    tick(1);
    host_we    = 1'b0;
    model[a]   = d;
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a, output logic [15:0] d);
    host_addr = a;
    tick(1);
    d = host_rdata;
  endtask

  // One SPI frame of nbits; optional reset before bit rst_at and optional host write
  // landing exactly on the cycle the 32nd rise commits.
  task automatic spi_frame(input logic [15:0] cmd, input logic [15:0] data, input int nbits,
                           input int rst_at, input logic collide,
                           input logic [ADDR_W-1:0] c_addr, input logic [15:0] c_data,
                           output logic [31:0] mb);
    logic [31:0] w;
    w  = {cmd, data};
    mb = '0;
    spi_cs_n = 1'b0;
    tick(6);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
      end
      spi_mosi = w[31-i];
      tick(HALF);
      spi_sclk = 1'b1;
      mb[31-i] = spi_miso;
      if (collide && i == 31) begin
        tick(SYNC_STAGES);
        host_we    = 1'b1;
        host_addr  = c_addr;
        host_wdata = c_data;
        tick(1);
        host_we    = 1'b0;
        tick(HALF - SYNC_STAGES - 1);
      end else begin
        tick(HALF);
      end
      spi_sclk = 1'b0;
    end
    tick(6);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    tick(4);
  endtask

  task automatic push_frame(input logic rd, input logic [ADDR_W-1:0] a, input logic [15:0] d);
    frame_t f;
    f.rd = rd;
    f.addr = a;
    f.wdata = d;
    exp_frames.push_back(f);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    vectors++;
    if (spi_miso !== 1'b0) begin
      miscompares++; $display("FAIL reset_miso: got %b expected 0", spi_miso);
    end
    vectors++;
    if (frame_done !== 1'b0) begin
      miscompares++; $display("FAIL reset_done: got %b expected 0", frame_done);
    end
    vectors++;
    if (frame_abort !== 1'b0) begin
      miscompares++; $display("FAIL reset_abort: got %b expected 0", frame_abort);
    end
    vectors++;
    if (frame_is_read !== 1'b0) begin
      miscompares++; $display("FAIL reset_is_read: got %b expected 0", frame_is_read);
    end
    vectors++;
    if (frame_addr !== '0) begin
      miscompares++; $display("FAIL reset_addr: got %h expected 0", frame_addr);
    end
    vectors++;
    if (frame_wdata !== 16'h0000) begin
      miscompares++; $display("FAIL reset_wdata: got %h expected 0000", frame_wdata);
    end
    vectors++;
    if (host_rdata !== 16'h0000) begin
      miscompares++; $display("FAIL reset_host_rdata: got %h expected 0000", host_rdata);
    end
    rst_n = 1'b1;
    tick(6);
  endtask

  task automatic test_spi_read();
    logic [31:0] mb;
    int d0;
    host_write(8'h1A, 16'hC0DE);
    exp_reads.push_back(model[8'h1A]);
    push_frame(1'b1, 8'h1A, 16'h0000);
    d0 = done_cnt;
    spi_frame(16'h00D2, 16'h0000, 32, -1, 1'b0, '0, '0, mb);
    vectors++;
    if (mb[15:0] !== exp_reads[0]) begin
      miscompares++; $display("FAIL read_miso: got %h expected %h", mb[15:0], exp_reads[0]);
    end
    void'(exp_reads.pop_front());
    vectors++;
    if (mb[31:16] !== 16'h0000) begin
      miscompares++; $display("FAIL read_cmd_miso: got %h expected 0000", mb[31:16]);
    end
    vectors++;
    if (done_cnt != d0 + 1) begin
      miscompares++; $display("FAIL read_done_count: got %0d expected %0d", done_cnt, d0 + 1);
    end
  endtask

  task automatic test_spi_write();
    logic [31:0] mb;
    logic [15:0] rd;
    int d0;
    push_frame(1'b0, 8'h1A, 16'hBEEF);
    d0 = done_cnt;
    spi_frame(16'h00D0, 16'hBEEF, 32, -1, 1'b0, '0, '0, mb);
    model[8'h1A] = 16'hBEEF;
    vectors++;
    if (mb !== 32'h0) begin
      miscompares++; $display("FAIL write_miso: got %h expected 00000000", mb);
    end
    vectors++;
    if (done_cnt != d0 + 1) begin
      miscompares++; $display("FAIL write_done_count: got %0d expected %0d", done_cnt, d0 + 1);
    end
    host_read(8'h1A, rd);
    vectors++;
    if (rd !== model[8'h1A]) begin
      miscompares++; $display("FAIL write_host_read: got %h expected %h", rd, model[8'h1A]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] mb;
    push_frame(1'b0, 8'h05, 16'hFACE);
    spi_frame(16'h0028, 16'hFACE, 32, -1, 1'b0, '0, '0, mb);
    model[8'h05] = 16'hFACE;
    exp_reads.push_back(model[8'h05]);
    push_frame(1'b1, 8'h05, 16'h0000);
    spi_frame(16'h002A, 16'h0000, 32, -1, 1'b0, '0, '0, mb);
    vectors++;
    if (mb[15:0] !== exp_reads[0]) begin
      miscompares++; $display("FAIL b2b_read: got %h expected %h", mb[15:0], exp_reads[0]);
    end
    void'(exp_reads.pop_front());
  endtask

  task automatic test_abort();
    logic [31:0] mb;
    logic [15:0] rd;
    int d0, a0;
    host_write(8'h05, 16'h1111);
    d0 = done_cnt;
    a0 = abort_cnt;
    spi_frame(16'h0028, 16'h2222, 20, -1, 1'b0, '0, '0, mb);
    vectors++;
    if (abort_cnt != a0 + 1) begin
      miscompares++; $display("FAIL abort_pulse: got %0d expected %0d", abort_cnt, a0 + 1);
    end
    vectors++;
    if (done_cnt != d0) begin
      miscompares++; $display("FAIL abort_no_done: got %0d expected %0d", done_cnt, d0);
    end
    host_read(8'h05, rd);
    vectors++;
    if (rd !== model[8'h05]) begin
      miscompares++; $display("FAIL abort_mem: got %h expected %h", rd, model[8'h05]);
    end
    exp_reads.push_back(model[8'h05]);
    push_frame(1'b1, 8'h05, 16'h0000);
    spi_frame(16'h002A, 16'h0000, 32, -1, 1'b0, '0, '0, mb);
    vectors++;
    if (mb[15:0] !== exp_reads[0]) begin
      miscompares++; $display("FAIL abort_next_read: got %h expected %h", mb[15:0], exp_reads[0]);
    end
    void'(exp_reads.pop_front());
    vectors++;
    if (done_cnt != d0 + 1) begin
      miscompares++; $display("FAIL abort_next_done: got %0d expected %0d", done_cnt, d0 + 1);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] mb;
    logic [15:0] e;
    int d0;
    e  = model[8'h1A];
    d0 = done_cnt;
    spi_frame(16'h00D2, 16'h0000, 32, 24, 1'b0, '0, '0, mb);
    vectors++;
    if (mb[15:8] !== e[15:8]) begin
      miscompares++; $display("FAIL rstmid_pre_bits: got %h expected %h", mb[15:8], e[15:8]);
    end
    vectors++;
    if (mb[7:0] !== 8'h00) begin
      miscompares++; $display("FAIL rstmid_miso_zero: got %h expected 00", mb[7:0]);
    end
    vectors++;
    if (done_cnt != d0) begin
      miscompares++; $display("FAIL rstmid_no_done: got %0d expected %0d", done_cnt, d0);
    end
    exp_reads.push_back(model[8'h1A]);
    push_frame(1'b1, 8'h1A, 16'h0000);
    spi_frame(16'h00D2, 16'h0000, 32, -1, 1'b0, '0, '0, mb);
    vectors++;
    if (mb[15:0] !== exp_reads[0]) begin
      miscompares++; $display("FAIL rstmid_next_read: got %h expected %h", mb[15:0], exp_reads[0]);
    end
    void'(exp_reads.pop_front());
  endtask

  task automatic test_collision();
    logic [31:0] mb;
    logic [15:0] rd;
    host_write(8'h1A, 16'h0000);
    push_frame(1'b0, 8'h1A, 16'hBEEF);
    spi_frame(16'h00D0, 16'hBEEF, 32, -1, 1'b1, 8'h1A, 16'h1234, mb);
    model[8'h1A] = 16'hBEEF;
    host_read(8'h1A, rd);
    vectors++;
    if (rd !== model[8'h1A]) begin
      miscompares++; $display("FAIL collide_same: got %h expected %h", rd, model[8'h1A]);
    end
    push_frame(1'b0, 8'h1A, 16'hA5A5);
    spi_frame(16'h00D0, 16'hA5A5, 32, -1, 1'b1, 8'h33, 16'h5555, mb);
    model[8'h1A] = 16'hA5A5;
    model[8'h33] = 16'h5555;
    host_read(8'h1A, rd);
    vectors++;
    if (rd !== model[8'h1A]) begin
      miscompares++; $display("FAIL collide_diff_spi: got %h expected %h", rd, model[8'h1A]);
    end
    host_read(8'h33, rd);
    vectors++;
    if (rd !== model[8'h33]) begin
      miscompares++; $display("FAIL collide_diff_host: got %h expected %h", rd, model[8'h33]);
    end
  endtask

  initial begin
    test_reset();
    test_spi_read();
    test_spi_write();
    test_back_to_back();
    test_abort();
    test_reset_mid_frame();
    test_collision();
    tick(10);
    vectors++;
    if (exp_frames.size() != 0) begin
      miscompares++;
      $display("FAIL frames_pending: got %0d outstanding expected 0", exp_frames.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
